// File: rtl/pipe_pkg.sv
// Shared types and helpers for the flopenr pipeline register.
package pipe_pkg;

  localparam int unsigned PIPE_N     = 64;
  localparam int unsigned PIPE_DEPTH = 3;
  localparam int unsigned MAX_DEPTH  = 64;

  // Layout of one pipeline stage at the default width.
  typedef struct packed {
    logic [PIPE_N-1:0] data;
    logic              valid;
  } stage_t;

  // Counts set bits. The pipe zero-extends its valid vector to MAX_DEPTH bits before calling this.
  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/flopenr_pipe_if.sv
// Control, data and tap signals of the flopenr pipeline register.
interface flopenr_pipe_if #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 3
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                 en;
  logic                 flush;
  logic [N-1:0]         d;
  logic                 d_valid;
  logic [N-1:0]         q;
  logic                 q_valid;
  logic [DEPTH*N-1:0]   taps;
  logic [DEPTH-1:0]     tap_valid;
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, taps, tap_valid, occupancy
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, taps, tap_valid, occupancy
  );
endinterface

// File: rtl/flopenr_stage.sv
// One resettable pipeline flop: sync active-low reset, sync clear, enable.
module flopenr_stage #(
  parameter int unsigned    W         = 65,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Clear beats enable; otherwise hold.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = RESET_VAL;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/flopenr_pipe.sv
// DEPTH-stage pipeline register with stall, flush, per-stage valid and debug taps.
module flopenr_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned  N         = PIPE_N,
  parameter int unsigned  DEPTH     = PIPE_DEPTH,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  flopenr_pipe_if.slave        bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned SW    = N + 1;
  localparam logic [SW-1:0] STAGE_RESET = {RESET_VAL, 1'b0};

  logic [SW-1:0]      stage_d [DEPTH];
  logic [SW-1:0]      stage_q [DEPTH];
  logic [DEPTH*N-1:0] taps;
  logic [DEPTH-1:0]   tap_valid;

  // Stage word layout: {data, valid}; stage 0 takes the input, stage k the one before it.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_d[k] = {bus.d, bus.d_valid};
    end else begin : g_body
      assign stage_d[k] = stage_q[k-1];
    end

    flopenr_stage #(
      .W         (SW),
      .RESET_VAL (STAGE_RESET)
    ) u_stage (
      .clk    (clk),
      .rst_ni (reset),
      .clr_i  (bus.flush),
      .en_i   (bus.en),
      .d_i    (stage_d[k]),
      .q_o    (stage_q[k])
    );
  end

  always_comb begin
    taps      = '0;
    tap_valid = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      taps[k*N +: N] = stage_q[k][SW-1:1];
      tap_valid[k]   = stage_q[k][0];
    end
  end

  assign bus.taps      = taps;
  assign bus.tap_valid = tap_valid;
  assign bus.q         = stage_q[DEPTH-1][SW-1:1];
  assign bus.q_valid   = stage_q[DEPTH-1][0];
  assign bus.occupancy = OCC_W'(popcount(MAX_DEPTH'(tap_valid)));

endmodule

// File: tb/tb_flopenr_pipe.sv
// Bench for flopenr_pipe: queue model for the DEPTH=3 pipe plus directed literal checks.
module tb_flopenr_pipe;

  localparam int unsigned N  = 64;
  localparam int unsigned DA = 3;
  localparam logic [63:0] RV_B = 64'hDEAD;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_cmp;
  int n_bad;

  flopenr_pipe_if #(.N(N), .DEPTH(DA)) bus_a ();
  flopenr_pipe_if #(.N(N), .DEPTH(1))  bus_b ();

  flopenr_pipe #(.N(N), .DEPTH(DA), .RESET_VAL('0)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  flopenr_pipe #(.N(N), .DEPTH(1), .RESET_VAL(RV_B)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: newest entry at index 0, length fixed at DA once reset has been seen.
  logic [63:0] m_data [$];
  bit          m_vld  [$];
  bit          m_known;

  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (!rst_a || (m_known && bus_a.flush)) begin
      m_data.delete();
      m_vld.delete();
      for (int i = 0; i < DA; i++) begin
        m_data.push_back(64'd0);
        m_vld.push_back(1'b0);
      end
      m_known = 1'b1;
    end else if (m_known && bus_a.en) begin
      m_data.push_front(bus_a.d);
      m_vld.push_front(bus_a.d_valid);
      void'(m_data.pop_back());
      void'(m_vld.pop_back());
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      int cnt;
      cnt = 0;
      for (int k = 0; k < DA; k++) begin
        chk($sformatf("model_tap%0d", k), bus_a.taps[k*N +: N], m_data[k]);
        chk($sformatf("model_tapv%0d", k), 64'(bus_a.tap_valid[k]), 64'(m_vld[k]));
        cnt += int'(m_vld[k]);
      end
      chk("model_q", bus_a.q, m_data[DA-1]);
      chk("model_qv", 64'(bus_a.q_valid), 64'(m_vld[DA-1]));
      chk("model_occ", 64'(bus_a.occupancy), 64'(cnt));
    end
  end

  task automatic drive_a(input logic en, input logic fl, input logic [63:0] d, input logic dv);
    bus_a.en      = en;
    bus_a.flush   = fl;
    bus_a.d       = d;
    bus_a.d_valid = dv;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] stream [5];
    logic [63:0] t5_d   [3];
    logic        t5_v   [3];
    n_cmp = 0;
    n_bad = 0;
    stream = '{64'd1, 64'd51, 64'd578, 64'd781, 64'd457};
    t5_d   = '{64'd480, 64'd0, 64'd484188};
    t5_v   = '{1'b1, 1'b0, 1'b1};

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(1'b1, 1'b0, 64'd51, 1'b1);
    bus_b.en = 1'b0; bus_b.flush = 1'b0; bus_b.d = 64'd0; bus_b.d_valid = 1'b0;

    // 1: reset dominates en/d
    repeat (4) begin
      tick();
      chk("t1_q", bus_a.q, 64'd0);
      chk("t1_qv", 64'(bus_a.q_valid), 64'd0);
      chk("t1_occ", 64'(bus_a.occupancy), 64'd0);
    end
    rst_a = 1'b1;

    // 2: stream, latency of DEPTH edges
    for (int i = 0; i < 5; i++) begin
      drive_a(1'b1, 1'b0, stream[i], 1'b1);
      tick();
      chk("t2_occ", 64'(bus_a.occupancy), 64'((i + 1 > 3) ? 3 : i + 1));
      if (i >= 2) chk("t2_q", bus_a.q, stream[i-2]);
    end
    chk("t2_tap0", bus_a.taps[63:0], 64'd457);
    chk("t2_tap1", bus_a.taps[127:64], 64'd781);

    // 3: stall holds everything
    drive_a(1'b0, 1'b0, 64'd5781, 1'b1);
    repeat (3) begin
      tick();
      chk("t3_q", bus_a.q, 64'd578);
      chk("t3_tap0", bus_a.taps[63:0], 64'd457);
      chk("t3_occ", 64'(bus_a.occupancy), 64'd3);
    end
    drive_a(1'b1, 1'b0, 64'd9, 1'b1);
    tick();
    chk("t3_resume_q", bus_a.q, 64'd781);
    chk("t3_resume_tap0", bus_a.taps[63:0], 64'd9);

    // 4: flush discards incoming data even with en
    drive_a(1'b1, 1'b1, 64'd15, 1'b1);
    tick();
    chk("t4_taps_lo", bus_a.taps[127:0] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    chk("t4_tap2", bus_a.taps[191:128], 64'd0);
    chk("t4_tapv", 64'(bus_a.tap_valid), 64'd0);
    chk("t4_occ", 64'(bus_a.occupancy), 64'd0);
    drive_a(1'b1, 1'b0, 64'd0, 1'b0);
    repeat (3) begin
      tick();
      chk("t4_no15_q", bus_a.q, 64'd0);
      chk("t4_no15_qv", 64'(bus_a.q_valid), 64'd0);
    end

    // 5: bubbles carry data but are not counted
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 1'b0, t5_d[i], t5_v[i]);
      tick();
    end
    chk("t5_occ3", 64'(bus_a.occupancy), 64'd2);
    chk("t5_q0", bus_a.q, 64'd480);
    chk("t5_qv0", 64'(bus_a.q_valid), 64'd1);
    drive_a(1'b1, 1'b0, 64'd7, 1'b0);
    tick();
    chk("t5_q1", bus_a.q, 64'd0);
    chk("t5_qv1", 64'(bus_a.q_valid), 64'd0);
    chk("t5_occ4", 64'(bus_a.occupancy), 64'd1);
    tick();
    chk("t5_q2", bus_a.q, 64'd484188);
    chk("t5_qv2", 64'(bus_a.q_valid), 64'd1);
    chk("t5_bubble_tap0", bus_a.taps[63:0], 64'd7);

    // Flush wins over stall; mid-stream reset wins over en
    drive_a(1'b1, 1'b0, 64'd33, 1'b1);
    repeat (3) tick();
    chk("fl_full_occ", 64'(bus_a.occupancy), 64'd3);
    drive_a(1'b0, 1'b1, 64'd44, 1'b1);
    tick();
    chk("fl_stall_occ", 64'(bus_a.occupancy), 64'd0);
    drive_a(1'b1, 1'b0, 64'd55, 1'b1);
    repeat (2) tick();
    chk("rst_pre_occ", 64'(bus_a.occupancy), 64'd2);
    rst_a = 1'b0;
    tick();
    chk("rst_mid_occ", 64'(bus_a.occupancy), 64'd0);
    chk("rst_mid_tap0", bus_a.taps[63:0], 64'd0);
    rst_a = 1'b1;
    tick();
    chk("refill_tap0", bus_a.taps[63:0], 64'd55);
    chk("refill_occ", 64'(bus_a.occupancy), 64'd1);

    // 6: DEPTH=1 with non-zero reset value
    tick();
    chk("t6_rst_q", bus_b.q, RV_B);
    chk("t6_rst_qv", 64'(bus_b.q_valid), 64'd0);
    rst_b = 1'b1;
    bus_b.en = 1'b1; bus_b.d = 64'd15; bus_b.d_valid = 1'b1;
    tick();
    chk("t6_q15", bus_b.q, 64'd15);
    chk("t6_qv15", 64'(bus_b.q_valid), 64'd1);
    chk("t6_occ", 64'(bus_b.occupancy), 64'd1);
    rst_b = 1'b0;
    bus_b.d = 64'd77;
    tick();
    chk("t6_rst_mid_q", bus_b.q, RV_B);
    chk("t6_rst_mid_occ", 64'(bus_b.occupancy), 64'd0);
    rst_b = 1'b1;
    bus_b.en = 1'b0;
    tick();
    chk("t6_hold_q", bus_b.q, RV_B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
